// File: rtl/rggen_irq_coalescer.sv
// rggen_irq_coalescer: merges enable/status pairs into one registered interrupt
// with per-source level/edge mode and event/time coalescing.
// Optional build macro: RGGEN_IRQ_COALESCER_ID_EN adds a registered
// lowest-index active-source ID (o_irq_id / o_irq_id_valid).
//
// state  | meaning
// IDLE   | no active source, irq low, counters cleared
// ACCUM  | at least one source active, counting events and cycles
// FIRE   | irq high until every active source is gone
module rggen_irq_coalescer #(
    parameter int                          TOTAL_INTERRUPTS = 8,
    parameter logic [TOTAL_INTERRUPTS-1:0] EDGE_MASK        = '0,
    parameter int                          COUNT_WIDTH      = 8,
    localparam int                         ID_WIDTH         = (TOTAL_INTERRUPTS > 1) ? $clog2(TOTAL_INTERRUPTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
    input  logic [TOTAL_INTERRUPTS-1:0] i_isr,
    input  logic [TOTAL_INTERRUPTS-1:0] i_clear,
    input  logic [COUNT_WIDTH-1:0]      i_threshold,
    input  logic [COUNT_WIDTH-1:0]      i_timeout,
    output logic                        o_irq,
    output logic [ID_WIDTH-1:0]         o_irq_id,
    output logic                        o_irq_id_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [TOTAL_INTERRUPTS-1:0]   isr_q;
    logic [TOTAL_INTERRUPTS-1:0]   pending_q, pending_d;
    logic [TOTAL_INTERRUPTS-1:0]   active_q;
    logic [COUNT_WIDTH-1:0]        ev_cnt_q, ev_cnt_d;
    logic [COUNT_WIDTH-1:0]        tmr_q, tmr_d;
    logic                          irq_q;

    logic [TOTAL_INTERRUPTS-1:0]   pending;
    logic [TOTAL_INTERRUPTS-1:0]   active;
    logic                          any_active;
    logic                          new_event;
    logic                          immediate;
    logic [COUNT_WIDTH:0]          ev_sum;
    logic [COUNT_WIDTH:0]          tmr_sum;

    // Edge latches only exist on edge bits; set beats a coincident clear.
    assign pending_d  = ((pending_q & ~i_clear) | (i_isr & ~isr_q)) & EDGE_MASK;
    assign pending    = (i_isr & ~EDGE_MASK) | pending_q;
    assign active     = pending & i_ier;
    assign any_active = |active;
    assign new_event  = |(active & ~active_q);
    assign immediate  = (i_threshold <= COUNT_WIDTH'(1)) || (i_timeout == '0);

    // Sums carry one extra bit so the compares never see a wrapped value.
    assign ev_sum  = {1'b0, ev_cnt_q} + {{COUNT_WIDTH{1'b0}}, new_event};
    assign tmr_sum = {1'b0, tmr_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};

    // Source history, edge latches and all FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            isr_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            ev_cnt_q  <= '0;
            tmr_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            isr_q     <= i_isr;
            pending_q <= pending_d;
            active_q  <= active;
            ev_cnt_q  <= ev_cnt_d;
            tmr_q     <= tmr_d;
            irq_q     <= (state_d == ST_FIRE);
        end
    end

    // Next-state and counter update; cancel is checked before fire.
    always_comb begin
        state_d  = state_q;
        ev_cnt_d = '0;
        tmr_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_active) begin
                    if (immediate) begin
                        state_d = ST_FIRE;
                    end else begin
                        state_d  = ST_ACCUM;
                        ev_cnt_d = COUNT_WIDTH'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if (!any_active) begin
                    state_d = ST_IDLE;
                end else if ((ev_sum >= {1'b0, i_threshold}) ||
                             (tmr_sum >= {1'b0, i_timeout})) begin
                    state_d = ST_FIRE;
                end else begin
                    ev_cnt_d = ev_sum[COUNT_WIDTH]  ? '1 : ev_sum[COUNT_WIDTH-1:0];
                    tmr_d    = tmr_sum[COUNT_WIDTH] ? '1 : tmr_sum[COUNT_WIDTH-1:0];
                end
            end
            ST_FIRE: begin
                if (!any_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_irq = irq_q;

`ifdef RGGEN_IRQ_COALESCER_ID_EN
    logic [ID_WIDTH-1:0] id_enc;
    logic [ID_WIDTH-1:0] id_q;
    logic                id_valid_q;

    // Priority encode: scanning downward leaves the lowest active index.
    always_comb begin
        id_enc = '0;
        for (int i = TOTAL_INTERRUPTS - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_enc = ID_WIDTH'(i);
            end
        end
    end

    // ID tracks active every cycle, independent of the coalescing state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q       <= '0;
            id_valid_q <= 1'b0;
        end else begin
            id_q       <= id_enc;
            id_valid_q <= any_active;
        end
    end

    assign o_irq_id       = id_q;
    assign o_irq_id_valid = id_valid_q;
`else
    assign o_irq_id       = '0;
    assign o_irq_id_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Bench for rggen_irq_coalescer: directed scenarios plus random traffic,
// checked every cycle against a cycle-count based behavioural model.
module tb_rggen_irq_coalescer;

    localparam int         N  = 8;
    localparam logic [7:0] EM = 8'h01;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ier, isr, clr, thr, tmo;
    logic       irq;
    logic [2:0] irq_id;
    logic       irq_id_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit [7:0] m_pend, m_isr_prev, m_act_prev;
    bit       m_accum, m_firing;
    int       m_start, m_events, cyc;
    bit       e_irq, e_valid;
    int       e_id;

    int step_no = 0;
    int first_irq = -1;
    int base;

    rggen_irq_coalescer #(
        .TOTAL_INTERRUPTS(N),
        .EDGE_MASK(EM),
        .COUNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_ier(ier),
        .i_isr(isr),
        .i_clear(clr),
        .i_threshold(thr),
        .i_timeout(tmo),
        .o_irq(irq),
        .o_irq_id(irq_id),
        .o_irq_id_valid(irq_id_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_isr_prev = '0; m_act_prev = '0;
        m_accum = 0; m_firing = 0; m_start = 0; m_events = 0;
        e_irq = 0; e_valid = 0; e_id = 0;
    endtask

    // One clock of the reference: a source set becomes "active"; the first
    // activation starts a window at cycle m_start; the window closes into a
    // firing period once enough distinct rises or enough cycles have passed.
    task automatic model_cycle();
        bit [7:0] pend, act;
        bit       any, nev, found;
        pend = (isr & ~EM) | m_pend;
        act  = pend & ier;
        any  = |act;
        nev  = |(act & ~m_act_prev);
        if (m_firing) begin
            m_firing = any;
        end else if (m_accum) begin
            if (!any) begin
                m_accum = 0;
            end else begin
                m_events += int'(nev);
                if (m_events >= int'(thr) || (cyc - m_start) >= int'(tmo)) begin
                    m_accum  = 0;
                    m_firing = 1;
                end
            end
        end else if (any) begin
            if (thr <= 1 || tmo == 0) begin
                m_firing = 1;
            end else begin
                m_accum  = 1;
                m_start  = cyc;
                m_events = 1;
            end
        end
`ifdef RGGEN_IRQ_COALESCER_ID_EN
        e_valid = any;
        e_id    = 0;
        found   = 0;
        for (int i = 0; i < N; i++) begin
            if (act[i] && !found) begin
                e_id  = i;
                found = 1;
            end
        end
`else
        e_valid = 0;
        e_id    = 0;
        found   = 0;
`endif
        m_pend     = ((m_pend & ~clr) | (isr & ~m_isr_prev)) & EM;
        m_isr_prev = isr;
        m_act_prev = act;
        cyc++;
        e_irq = m_firing;
    endtask

    task automatic step();
        if (rst) model_reset();
        else model_cycle();
        @(posedge clk);
        #1;
        step_no++;
        check_eq("irq", irq, e_irq);
        check_eq("irq_id", irq_id, e_id);
        check_eq("irq_id_valid", irq_id_valid, e_valid);
        if (irq && first_irq < 0) first_irq = step_no;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic arm();
        base      = step_no;
        first_irq = -1;
    endtask

    initial begin
        rst = 1; ier = 0; isr = 0; clr = 0; thr = 0; tmo = 8'd255;
        model_reset();
        cyc = 0;
        #1;
        check_eq("reset_irq", irq, 0);
        check_eq("reset_valid", irq_id_valid, 0);
        steps(2);
        rst = 0;
        steps(2);

        // immediate level
        ier = 8'hFF; thr = 0;
        arm();
        isr = 8'h04;
        steps(9);
        check_eq("imm_latency", first_irq - base, 1);
        isr = 8'h00;
        step();
        check_eq("imm_drop", irq, 0);
        steps(2);

        // event threshold, distinct rises
        thr = 3; tmo = 255;
        arm();
        isr = 8'h02; steps(4);
        isr = 8'h22; steps(4);
        isr = 8'h62; steps(2);
        check_eq("evt_latency", first_irq - base, 9);
        isr = 0; steps(3);

        // simultaneous rise counts once
        arm();
        isr = 8'h02; steps(4);
        isr = 8'h62; steps(5);
        check_eq("evt_simul_nofire", first_irq, -1);
        isr = 0; steps(3);

        // timeout
        thr = 200; tmo = 4;
        arm();
        isr = 8'h02; steps(6);
        check_eq("tmo_latency", first_irq - base, 5);
        isr = 0; steps(3);

        // cancel with two events accumulated, then restart from one
        thr = 3; tmo = 255;
        arm();
        isr = 8'h02; step();
        isr = 8'h06; step();
        isr = 8'h00; steps(2);
        check_eq("cancel_nofire", first_irq, -1);
        arm();
        isr = 8'h02; step();
        isr = 8'h06; step();
        isr = 8'h0E; steps(2);
        check_eq("restart_latency", first_irq - base, 3);
        isr = 0; steps(3);

        // edge latch and clear
        thr = 0;
        arm();
        isr = 8'h01; step();
        isr = 8'h00; steps(5);
        check_eq("edge_latency", first_irq - base, 2);
        check_eq("edge_held", irq, 1);
        clr = 8'h01; step();
        clr = 8'h00;
        check_eq("clear_1cyc", irq, 1);
        step();
        check_eq("clear_2cyc", irq, 0);
        steps(2);
        isr = 8'h01; clr = 8'h01; step();
        isr = 8'h00; clr = 8'h00; steps(3);
        check_eq("set_wins", irq, 1);
        clr = 8'h01; step();
        clr = 8'h00; steps(2);

        // asynchronous reset while firing; latch must come back clear
        isr = 8'h01; steps(3);
        check_eq("pre_rst_fire", irq, 1);
        rst = 1;
        #1;
        check_eq("async_rst_irq", irq, 0);
        isr = 8'h00;
        step();
        rst = 0;
        steps(3);
        check_eq("post_rst_idle", irq, 0);

        // masking
        ier = 8'h00; isr = 8'hFF; steps(3);
        check_eq("mask_irq", irq, 0);
        check_eq("mask_valid", irq_id_valid, 0);
        ier = 8'h80; steps(2);
        check_eq("unmask_irq", irq, 1);
        isr = 0; ier = 8'hFF; steps(3);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) isr = isr ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ier = ier ^ (8'h01 << $urandom_range(0, 7));
            clr = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            if ($urandom_range(0, 99) == 0) begin
                thr = 8'($urandom_range(0, 6));
                tmo = 8'($urandom_range(0, 12));
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 0;
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rggen_irq_coalescer.md
Name: rggen_irq_coalescer

Overview:
- Parametrised successor to the fixed level-only interrupt controller used in generated register blocks.
- Combines TOTAL_INTERRUPTS enable/status pairs into one registered interrupt line.
- Adds per-source level or edge mode, internal edge pending latches, and event/time coalescing.
- Optionally adds a registered lowest-index active-source ID output.
- Instantiated beside the host interface in a register block. Inputs come from register_if value bits.

Parameters:
- TOTAL_INTERRUPTS, 8: number of sources, N ≥ 1.
- EDGE_MASK, '0 (N bits): bit i = 1 makes source i rising-edge; 0 makes it level.
- COUNT_WIDTH, 8: width of the coalescing threshold, timeout and internal counters.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- i_ier  input  N  per-source enable.
- i_isr  input  N  per-source status.
- i_clear  input  N  per-source clear pulse for edge pending latches; ignored for level sources.
- i_threshold  input  COUNT_WIDTH  events needed before firing; 0 or 1 means fire immediately.
- i_timeout  input  COUNT_WIDTH  maximum cycles spent accumulating; 0 means fire immediately.
- o_irq  output  1  registered interrupt.
- o_irq_id  output  max(1,$clog2(N))  lowest-index active source.
- o_irq_id_valid  output  1  o_irq_id is meaningful.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, pending latches 0, isr history 0. Reset is asynchronous and active-high. Asserting it mid-operation aborts any state back to IDLE immediately.
- Level source i: pending[i] = i_isr[i], combinational.
- Edge source i: pending_q[i] sets on i_isr[i] & ~isr_d[i] (isr_d is i_isr registered). It clears on i_clear[i]. If set and clear occur in the same cycle, set wins.
- active = pending & i_ier. any_active = |active.
- new_event: at least one active bit rose this cycle (active & ~active_d). A cycle with several rising bits counts as one event.
- State IDLE:
  - o_irq = 0.
  - If any_active and (i_threshold ≤ 1 or i_timeout == 0): go to FIRE.
  - Otherwise, if any_active: go to ACCUM with ev_cnt = 1 and tmr = 0.
- State ACCUM:
  - Each cycle tmr += 1 (saturating). ev_cnt += new_event (saturating).
  - If !any_active: go to IDLE (cancel). Cancel takes priority over fire.
  - Else if ev_cnt + new_event ≥ i_threshold or tmr + 1 ≥ i_timeout: go to FIRE.
- State FIRE:
  - o_irq = 1.
  - Stays in FIRE while any_active. Goes to IDLE on the cycle after any_active is 0.
  - Counters are held at 0.
- o_irq is a flop: it reflects the next state, so it asserts 1 cycle after the IDLE→FIRE or ACCUM→FIRE decision cycle.
- Immediate-mode latency: status and enable high at cycle k → o_irq = 1 at k+1. Edge sources add 1 cycle for the pending latch.
- Changing i_threshold or i_timeout during ACCUM takes effect on the next compare. No restart.
- Counters compare at COUNT_WIDTH width. Saturation prevents wrap-around at the maximum value.
- An N = 1 build must synthesise; o_irq_id is then 1 bit, always 0.

Optional Feature:
- Macro: RGGEN_IRQ_COALESCER_ID_EN.
- Defined:
  - o_irq_id is a registered lowest-set-bit encode of active.
  - o_irq_id_valid is registered any_active, both with 1-cycle latency.
  - Both update every cycle regardless of state.
- Undefined: o_irq_id and o_irq_id_valid tied to 0; no encoder logic.
- Coalescing behaviour is identical in both builds.

Test Plan:
- Immediate level: N=8, threshold=0; ier=8'hFF, isr=8'h04 at cycle 10 → o_irq=1 at cycle 11 (with macro: id=2, valid=1). isr=0 at cycle 20 → o_irq=0 at cycle 21.
- Event threshold: threshold=3, timeout=255; rising edges on sources 1, 5, 6 at cycles 10, 14, 18 → o_irq stays 0 until cycle 19. Simultaneous rise of 5 and 6 at cycle 14 counts as one event → no fire by cycle 18.
- Timeout: threshold=200, timeout=4; single level source active from cycle 10 → o_irq=1 at cycle 15.
- Edge latch and clear: EDGE_MASK=8'h01; isr[0] pulses for 1 cycle → pending held and o_irq stays high. i_clear[0] → o_irq drops after 2 cycles. Clear coincident with a new rising edge → pending stays set.
- Cancel and reset: source drops during ACCUM → IDLE, o_irq never asserts, and the next activation restarts ev_cnt=1. rst asserted while in FIRE → o_irq=0 asynchronously, pending latches cleared.
- Masking: isr=8'hFF, ier=0 → o_irq=0 and id_valid=0. Set ier[7]=1 → fires with id=7.
